// File: rtl/uncached_store_buffer_pkg.sv
// Shared types and AXI constants for the uncached store buffer.
// FSM encoding, queued store entry layout, fixed AXI field codes.
package uncached_store_buffer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR_DATA,
    S_RESP
  } usb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
  } usb_entry_t;

  localparam int ENTRY_W = $bits(usb_entry_t);

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/sync_fifo_ram.sv
// Entry storage for the store buffer: one write port, async read.
// Contents are don't-care until written, so no reset is applied.
module sync_fifo_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 71,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uncached_store_buffer.sv
// FIFO of uncached stores drained one at a time as single-beat
// AXI3 writes; one write outstanding, strict program order.
module uncached_store_buffer
  import uncached_store_buffer_pkg::*;
#(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] AXI_ID = 4'h1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        push_en,
  input  logic [31:0] push_addr,
  input  logic [31:0] push_wdata,
  input  logic [3:0]  push_wstrb,
  input  logic [2:0]  push_size,
  output logic        full,
  output logic        empty,
  output logic        bus_err,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  usb_state_e    state, state_n;
  logic          aw_done, aw_done_n;
  logic          w_done, w_done_n;
  logic          load;
  logic          push_ok;
  logic          pop;
  logic [PW-1:0] head, tail, rd_ptr;
  logic [CW-1:0] count;
  usb_entry_t    wr_ent, rd_ent;
  logic          unused_bid;

  assign unused_bid = ^bid;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push_en && !full;
  assign pop     = (state == S_RESP) && bvalid;

  assign awvalid = (state == S_ADDR_DATA) && !aw_done;
  assign wvalid  = (state == S_ADDR_DATA) && !w_done;
  assign bready  = (state == S_RESP);

  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wlast   = 1'b1;

  assign wr_ent = '{
    addr: push_addr,
    data: push_wdata,
    strb: push_wstrb,
    size: push_size
  };

  // On a retiring B the next write starts from the following slot
  assign rd_ptr = (state == S_RESP) ? head + PW'(1) : head;

  sync_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (aclk),
    .we    (push_ok),
    .waddr (tail),
    .wdata (wr_ent),
    .raddr (rd_ptr),
    .rdata (rd_ent)
  );

  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    load      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0) begin
          state_n = S_ADDR_DATA;
          load    = 1'b1;
        end
      end
      S_ADDR_DATA: begin
        aw_done_n = aw_done || (awvalid && awready);
        w_done_n  = w_done || (wvalid && wready);
        if (aw_done_n && w_done_n) begin
          state_n   = S_RESP;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      S_RESP: begin
        if (bvalid) begin
          // Old count: a same-cycle push into an emptying buffer waits
          if (count > CW'(1)) begin
            state_n = S_ADDR_DATA;
            load    = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
      if (push_ok) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      if (push_ok && !pop) count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      if (pop && (bresp != AXI_RESP_OKAY)) bus_err <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awaddr <= '0;
      awsize <= '0;
      wdata  <= '0;
      wstrb  <= '0;
    end else if (load) begin
      awaddr <= rd_ent.addr;
      awsize <= rd_ent.size;
      wdata  <= rd_ent.data;
      wstrb  <= rd_ent.strb;
    end
  end

endmodule

// File: doc/uncached_store_buffer.md
UNCACHED_STORE_BUFFER -- requirements
Module: uncached_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter AXI_ID, default 4'h1, constant awid/wid value.
REQ-003 aclk  in  1  sole clock; all logic on rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 push_en  in  1  DCache-controller request to enqueue one uncached store.
REQ-006 push_addr  in  32  store physical address; push_wdata  in  32  store data; push_wstrb  in  4  byte enables; push_size  in  3  AXI size code.
REQ-007 full  out  1  buffer cannot accept a push; empty  out  1  no stored or in-flight entries.
REQ-008 bus_err  out  1  sticky: some B response was non-OKAY.
REQ-009 AXI3 write master: awid 4, awaddr 32, awlen 4, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid 1 (out); awready 1 (in); wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1 (out); wready 1 (in); bid 4, bresp 2, bvalid 1 (in); bready 1 (out).

Function
REQ-010 Push accepted in cycle where push_en=1 and full=0; entry written at tail, tail++ mod DEPTH, count++.
REQ-011 full SHALL equal (count==DEPTH), registered-state-derived; push while full ignored, no state change.
REQ-012 empty SHALL equal (count==0); entry counts until its B handshake completes.
REQ-013 FSM states IDLE, ADDR_DATA, RESP.
REQ-014 IDLE -> ADDR_DATA when count>0; next cycle awvalid=1 and wvalid=1 with head entry.
REQ-015 In ADDR_DATA, AW and W handshakes tracked by separate done flags; each valid drops after own handshake; either order or same cycle allowed; -> RESP when both done.
REQ-016 awaddr/awsize/wdata/wstrb SHALL hold stable while respective valid is high.
REQ-017 In RESP bready=1; on bvalid: head++ mod DEPTH, count--, -> IDLE (or directly ADDR_DATA if count-1>0). bready=0 outside RESP.
REQ-018 At most one outstanding write; strict FIFO order.
REQ-019 Simultaneous push and B-pop: count unchanged, both pointers advance; if full at that cycle push still refused.
REQ-020 bresp!=2'b00 at B handshake sets bus_err; bid ignored; entry still retired.
REQ-021 Constants: awid=wid=AXI_ID, awlen=0, awburst=2'b01, awlock=0, awcache=0, awprot=0, wlast=1.
REQ-022 Minimum latency push -> awvalid: 2 cycles from empty (push edge, IDLE->ADDR_DATA edge).

Reset
REQ-023 aresetn=0 SHALL immediately clear count, head, tail, done flags, bus_err; FSM -> IDLE.
REQ-024 Reset values: awvalid=wvalid=bready=0, full=0, empty=1, bus_err=0; address/data outputs 0.
REQ-025 Reset mid-transaction abandons in-flight write and all entries; no retry after release.
REQ-026 FIFO storage array need not be reset.

Structure
REQ-027 State encoding, AXI burst/size constants and OKAY code SHALL live in the shared defines package.
REQ-028 Storage SHALL be one sub-module sync_fifo_ram (DEPTH x 71 bits, 1 write, 1 async read port).

Verification
REQ-029 Single push addr 0x1FAF_F000, data 0xDEADBEEF, strb 4'hF, size 2, ready signals tied 1 -> AW+W same cycle at push+2, B next cycle, empty=1 at push+4.
REQ-030 Four pushes back-to-back, awready held 0 -> full=1 after 4th; 5th push ignored; release awready -> four writes in push order, full drops at first B.
REQ-031 wready 3 cycles before awready -> wvalid drops after W handshake, awvalid remains, RESP entered only after AW handshake.
REQ-032 Push coincident with bvalid&&bready at count=2 -> count stays 2, order preserved.
REQ-033 bresp=2'b10 on second write -> bus_err=1 and stays 1; third write proceeds normally.
REQ-034 aresetn low while awvalid=1 with 3 entries -> outputs at reset values in same cycle, empty=1, no further AW after release.
